bluetooth_ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 32-bit on-chip RAM (51200 words, 1-cycle read latency) between the Nios data master (port m0) and the Bluetooth UART receive/transmit DMA (port m1). Sits between both Avalon-MM masters and the RAM's s1 slave interface. Provides round-robin grant with a bounded hold window, routing of read responses, and optional address range checking.

---
 rtl/bluetooth_ram_arbiter_if.sv | 35 +++
 rtl/bluetooth_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bluetooth_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bluetooth_ram_arbiter_if.sv
// Avalon-MM requester bundle for one port of the Bluetooth RAM arbiter.
// The master modport is the requester side (Nios data master or the UART DMA).
// The slave modport is the arbiter side: it returns waitrequest and read responses.
//
// Signals:
//   read, write      command strobes (mutually exclusive)
//   address          word address
//   byteenable       byte lanes, DATA_W/8 bits
//   writedata        write data
//   waitrequest      command stalled this cycle
//   readdata         read data
//   readdatavalid    readdata valid
interface bluetooth_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/bluetooth_ram_arbiter.sv
// Purpose: share the single-port on-chip RAM between the Nios data master (m0) and the BT UART DMA (m1).
// Latency: grant/waitrequest are combinational; read data returns one cycle after the command is accepted.
// Backpressure: the losing requester sees waitrequest; the winner is held for at most MAX_HOLD transfers while the other waits.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   m0, m1                   requester ports (bluetooth_ram_arbiter_if.slave)
//   ram_address/byteenable/writedata/chipselect/write/clken  RAM s1 command side
//   ram_readdata             RAM q, valid one cycle after a read address
//   range_err                sticky out-of-range flag
//
// Optional feature: define BT_RAM_ARB_RANGE_CHK_EN to suppress RAM access for
// addresses >= NUM_WORDS, return zero read data for them and raise range_err.
// Without it the address passes through unchecked and range_err is tied 0.
module bluetooth_ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 51200,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bluetooth_ram_arbiter_if.slave m0,
  bluetooth_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [DATA_W/8-1:0]  ram_byteenable,
  output logic [DATA_W-1:0]    ram_writedata,
  output logic                 ram_chipselect,
  output logic                 ram_write,
  output logic                 ram_clken,
  input  logic [DATA_W-1:0]    ram_readdata,
  output logic                 range_err
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  // Arbitration state
  logic       last_q, last_d;          // last granted master
  logic [3:0] hold_q, hold_d;          // consecutive accepts of last_q
  logic       rsp_pend_q, rsp_pend_d;  // a read response is due this cycle
  logic       rsp_owner_q, rsp_owner_d;

  logic req0, req1;
  logic gnt_vld;   // some command is accepted this cycle
  logic gnt_sel;   // 0 = m0, 1 = m1
  logic acc_rd, acc_wr;
  logic cmd_hit;   // accepted command actually reaches the RAM
  logic [DATA_W-1:0] rsp_data;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Grant selection. hold_q == 0 means nothing has been accepted since the
  // last idle cycle, so the master that did not go last gets the first turn.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0 && req1) begin
      if (hold_q == 4'd0 || hold_q >= HOLD_MAX) begin
        gnt_sel = ~last_q;
      end else begin
        gnt_sel = last_q;
      end
    end else begin
      gnt_sel = req1;
    end
  end

  // Nothing is accepted while reset is asserted; a request held across reset
  // is simply re-arbitrated once reset drops.
  assign gnt_vld = ~reset & (req0 | req1);
  assign acc_rd  = gnt_vld & (gnt_sel ? m1.read  : m0.read);
  assign acc_wr  = gnt_vld & (gnt_sel ? m1.write : m0.write);

  // Command mux towards the RAM
  assign ram_address    = gnt_sel ? m1.address    : m0.address;
  assign ram_byteenable = gnt_sel ? m1.byteenable : m0.byteenable;
  assign ram_writedata  = gnt_sel ? m1.writedata  : m0.writedata;
  assign ram_clken      = 1'b1;

  // Waitrequest only for a requesting master that lost; gated in reset so
  // every output shows its reset value.
  assign m0.waitrequest = ~reset & req0 & ~(gnt_vld & ~gnt_sel);
  assign m1.waitrequest = ~reset & req1 & ~(gnt_vld &  gnt_sel);

  // Next-state for arbitration and response tracking
  always_comb begin
    last_d      = last_q;
    hold_d      = hold_q;
    rsp_pend_d  = 1'b0;
    rsp_owner_d = rsp_owner_q;
    if (gnt_vld) begin
      last_d = gnt_sel;
      if (gnt_sel != last_q) begin
        hold_d = 4'd1;
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 4'd1;
      end
    end else begin
      hold_d = 4'd0;
    end
    if (acc_rd) begin
      rsp_pend_d  = 1'b1;
      rsp_owner_d = gnt_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      hold_q      <= 4'd0;
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      hold_q      <= hold_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

`ifdef BT_RAM_ARB_RANGE_CHK_EN
  localparam logic [31:0] NUM_WORDS_C = 32'(NUM_WORDS);

  logic        cmd_oor;
  logic        rsp_oor_q, rsp_oor_d;
  logic        range_err_q, range_err_d;

  // Out-of-range commands still complete their handshake but never touch the RAM.
  assign cmd_oor = gnt_vld & (32'(ram_address) >= NUM_WORDS_C);
  assign cmd_hit = gnt_vld & ~cmd_oor;

  always_comb begin
    rsp_oor_d   = acc_rd & cmd_oor;
    range_err_d = range_err_q | cmd_oor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_oor_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      rsp_oor_q   <= rsp_oor_d;
      range_err_q <= range_err_d;
    end
  end

  // The RAM was not read for an out-of-range response, so return zero.
  assign rsp_data  = rsp_oor_q ? '0 : ram_readdata;
  assign range_err = range_err_q;
`else
  assign cmd_hit   = gnt_vld;
  assign rsp_data  = ram_readdata;
  assign range_err = 1'b0;
`endif

  assign ram_chipselect = cmd_hit;
  assign ram_write      = cmd_hit & acc_wr;

  // Both ports see the RAM output; readdatavalid picks the owner. A response
  // due in a reset cycle is dropped.
  assign m0.readdata      = rsp_data;
  assign m1.readdata      = rsp_data;
  assign m0.readdatavalid = ~reset & rsp_pend_q & ~rsp_owner_q;
  assign m1.readdatavalid = ~reset & rsp_pend_q &  rsp_owner_q;

endmodule

// File: tb/tb_bluetooth_ram_arbiter.sv
module tb_bluetooth_ram_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 51200;
  localparam int MAX_HOLD  = 4;
`ifdef BT_RAM_ARB_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bluetooth_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  bluetooth_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic [31:0]       ram_readdata;
  logic              ram_chipselect, ram_write, ram_clken, range_err;

  bluetooth_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .m0(m0_if.slave), .m1(m1_if.slave),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .range_err(range_err)
  );

  // RAM environment: single port, one-cycle read latency, byte-lane writes.
  logic [31:0] ram_mem [0:65535];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
      end else begin
        ram_q = ram_mem[ram_address];
      end
    end
  end
  assign ram_readdata = ram_q;

  // Reference model: expected memory contents, arbitration history, pending response.
  logic [31:0] exp_mem [0:65535];
  int          last_g;      // which master went last
  int          streak;      // consecutive accepts of last_g since last idle cycle
  bit          pend;        // response expected this cycle
  int          owner;
  logic [31:0] pdata;
  bit          rerr;
  int          last_pick;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (streak == 0 || streak >= MAX_HOLD) return 1 - last_g;
    return last_g;
  endfunction

  task automatic model_reset();
    last_g = 1; streak = 0; pend = 0; owner = 0; pdata = '0; rerr = 0;
  endtask

  task automatic drv0(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
    m0_if.byteenable = be; m0_if.writedata = d;
  endtask

  task automatic drv1(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
    m1_if.byteenable = be; m1_if.writedata = d;
  endtask

  task automatic idle();
    drv0(0, 0, '0, '0, '0);
    drv1(0, 0, '0, '0, '0);
  endtask

  // One clock cycle: compare all outputs against the model, then advance.
  task automatic cyc();
    bit r0, r1, wr, oor, pend_n;
    int g;
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] wd, pdata_n;
    #1;
    r0 = m0_if.read | m0_if.write;
    r1 = m1_if.read | m1_if.write;
    g  = pick(r0, r1);
    last_pick = g;
    chk("m0_waitrequest",   m0_if.waitrequest,   32'(r0 && g != 0));
    chk("m1_waitrequest",   m1_if.waitrequest,   32'(r1 && g != 1));
    chk("m0_readdatavalid", m0_if.readdatavalid, 32'(pend && owner == 0));
    chk("m1_readdatavalid", m1_if.readdatavalid, 32'(pend && owner == 1));
    if (pend) chk("readdata", (owner == 0) ? m0_if.readdata : m1_if.readdata, pdata);
    pend_n = 0; pdata_n = '0;
    if (g >= 0) begin
      a   = (g == 0) ? m0_if.address    : m1_if.address;
      be  = (g == 0) ? m0_if.byteenable : m1_if.byteenable;
      wd  = (g == 0) ? m0_if.writedata  : m1_if.writedata;
      wr  = (g == 0) ? m0_if.write      : m1_if.write;
      oor = CHK && (int'(a) >= NUM_WORDS);
      chk("ram_chipselect", ram_chipselect, 32'(!oor));
      chk("ram_write",      ram_write,      32'(wr && !oor));
      if (!oor) begin
        chk("ram_address",    ram_address,    a);
        chk("ram_byteenable", ram_byteenable, be);
        if (wr) chk("ram_writedata", ram_writedata, wd);
      end
      if (oor) rerr = 1;
      if (wr && !oor)
        for (int b = 0; b < 4; b++)
          if (be[b]) exp_mem[a][8*b +: 8] = wd[8*b +: 8];
      if (!wr) begin
        pend_n  = 1;
        pdata_n = oor ? 32'h0 : exp_mem[a];
        owner   = g;
      end
      if (g != last_g) streak = 1;
      else if (streak < MAX_HOLD) streak++;
      last_g = g;
    end else begin
      chk("ram_chipselect_idle", ram_chipselect, 0);
      streak = 0;
    end
    chk("range_err", range_err, 32'(rerr));
    @(posedge clk);
    #1;
    pend  = pend_n;
    pdata = pdata_n;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_m0_waitrequest",   m0_if.waitrequest,   0);
      chk("rst_m1_waitrequest",   m1_if.waitrequest,   0);
      chk("rst_m0_readdatavalid", m0_if.readdatavalid, 0);
      chk("rst_m1_readdatavalid", m1_if.readdatavalid, 0);
      chk("rst_ram_chipselect",   ram_chipselect,      0);
      chk("rst_ram_write",        ram_write,           0);
      if (i > 0) chk("rst_range_err", range_err, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] v;
    int k0, k1;
    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      exp_mem[i] = v;
    end
    ram_mem[16'h0010] = 32'hA5A5_0001; exp_mem[16'h0010] = 32'hA5A5_0001;
    ram_mem[16'h0100] = 32'h1234_5678; exp_mem[16'h0100] = 32'h1234_5678;
    model_reset();
    last_pick = -1;
    idle();

    // Reset state, with m0 requesting throughout
    drv0(1, 0, 16'h0030, 4'hF, '0);
    do_reset(3);
    idle();
    chk("ram_clken", ram_clken, 1);

    // Lone m0 read of a preloaded word
    drv0(1, 0, 16'h0010, 4'hF, '0);
    cyc();
    idle();
    #1;
    chk("t1_m0_rdv",   m0_if.readdatavalid, 1);
    chk("t1_m0_rdata", m0_if.readdata,      32'hA5A5_0001);
    chk("t1_m1_rdv",   m1_if.readdatavalid, 0);
    cyc();

    // Both masters stream reads from reset: m0 x4, m1 x4, m0 x4
    do_reset(1);
    drv0(1, 0, 16'h0020, 4'hF, '0);
    drv1(1, 0, 16'h0040, 4'hF, '0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("t2_grant", last_pick, (i / 4) % 2);
    end
    idle();
    cyc();

    // Partial write by m1 then m0 reads the merged word
    drv1(0, 1, 16'h0100, 4'b0011, 32'hDEAD_BEEF);
    cyc();
    idle();
    drv0(1, 0, 16'h0100, 4'hF, '0);
    cyc();
    idle();
    #1;
    chk("t3_merge", m0_if.readdata, 32'h1234_BEEF);
    cyc();

    // Reset in the cycle after an accepted read drops the response
    drv0(1, 0, 16'h0010, 4'hF, '0);
    cyc();
    reset = 1'b1;
    #1;
    chk("t4_m0_rdv",  m0_if.readdatavalid, 0);
    chk("t4_m0_wait", m0_if.waitrequest,   0);
    chk("t4_cs",      ram_chipselect,      0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc();            // held request re-arbitrated from reset state
    idle();
    cyc();

    // Address at NUM_WORDS
    drv1(0, 1, 16'hC800, 4'hF, 32'h0000_0055);
    cyc();
    idle();
    cyc();
    cyc();
    drv1(1, 0, 16'hC800, 4'hF, '0);
    cyc();
    idle();
    #1;
    chk("t5_rdata",     m1_if.readdata,      CHK ? 32'h0 : 32'h0000_0055);
    chk("t5_rdv",       m1_if.readdatavalid, 1);
    chk("t5_range_err", range_err,           32'(CHK));
    cyc();

    // m1 alone alternating read/write, m0 idle
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      drv1(i % 2 == 0, i % 2 == 1, 16'($urandom_range(0, 63)),
           4'($urandom_range(1, 15)), $urandom);
      #1;
      chk("t6_m1_wait", m1_if.waitrequest, 0);
      cyc();
    end
    idle();
    cyc();

    // Randomised traffic from both masters
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      drv0(k0 == 1 || k0 == 3, k0 == 2,
           ($urandom_range(0, 31) == 0) ? 16'(NUM_WORDS + $urandom_range(0, 7))
                                        : 16'($urandom_range(0, 63)),
           4'($urandom_range(0, 15)), $urandom);
      drv1(k1 == 1 || k1 == 3, k1 == 2,
           ($urandom_range(0, 31) == 0) ? 16'(NUM_WORDS + $urandom_range(0, 7))
                                        : 16'($urandom_range(0, 63)),
           4'($urandom_range(0, 15)), $urandom);
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
